// File: rtl/axi_rd_interconnect_nxm.sv
// axi_rd_interconnect_nxm: NUM_M x NUM_S AXI read-channel interconnect.
// A single shared path carries one transaction at a time. Masters are
// arbitrated round-robin, and the address is decoded against per-slave
// inclusive windows. Unmapped reads get a DECERR burst that is generated
// internally.
module axi_rd_interconnect_nxm #(
  parameter int NUM_M  = 2,
  parameter int NUM_S  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MW     = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                       G_clk,
  input  logic                       G_reset,
  input  logic [NUM_M*ADDR_W-1:0]    M_ARADDR,
  input  logic [NUM_M*4-1:0]         M_ARLEN,
  input  logic [NUM_M*3-1:0]         M_ARSIZE,
  input  logic [NUM_M*2-1:0]         M_ARBURST,
  input  logic [NUM_M-1:0]           M_ARVALID,
  input  logic [NUM_M-1:0]           M_RREADY,
  output logic [NUM_M-1:0]           M_ARREADY,
  output logic [NUM_M-1:0]           M_RVALID,
  output logic [NUM_M-1:0]           M_RLAST,
  output logic [NUM_M*2-1:0]         M_RRESP,
  output logic [NUM_M*DATA_W-1:0]    M_RDATA,
  output logic [NUM_S*ADDR_W-1:0]    S_ARADDR,
  output logic [NUM_S*4-1:0]         S_ARLEN,
  output logic [NUM_S*3-1:0]         S_ARSIZE,
  output logic [NUM_S*2-1:0]         S_ARBURST,
  output logic [NUM_S-1:0]           S_ARVALID,
  output logic [NUM_S-1:0]           S_RREADY,
  input  logic [NUM_S-1:0]           S_ARREADY,
  input  logic [NUM_S-1:0]           S_RVALID,
  input  logic [NUM_S-1:0]           S_RLAST,
  input  logic [NUM_S*2-1:0]         S_RRESP,
  input  logic [NUM_S*DATA_W-1:0]    S_RDATA,
  input  logic [NUM_S*ADDR_W-1:0]    SLV_BASE,
  input  logic [NUM_S*ADDR_W-1:0]    SLV_LIMIT,
  output logic                       busy,
  output logic [MW-1:0]              grant_id
);

  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t          state, state_nxt;
  logic [MW-1:0]   gnt, gnt_nxt;
  logic [MW-1:0]   ptr, ptr_nxt;
  logic [SW-1:0]   sel, sel_nxt;
  logic [3:0]      cnt, cnt_nxt;

  logic [MW-1:0]     arb_idx;
  logic              arb_found;
  logic [SW-1:0]     dec_idx;
  logic              dec_hit;
  logic [ADDR_W-1:0] g_addr;

  assign g_addr = M_ARADDR[int'(gnt)*ADDR_W +: ADDR_W];

  // Round-robin search: first requesting master at or after ptr, with wrap-around
  always_comb begin
    int idx;
    idx       = 0;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      idx = (int'(ptr) + int'(k)) % NUM_M;
      if (!arb_found && M_ARVALID[idx]) begin
        arb_found = 1'b1;
        arb_idx   = MW'(idx);
      end
    end
  end

  // Address decode of the registered grant; the lowest matching window wins
  always_comb begin
    dec_idx = '0;
    dec_hit = 1'b0;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      if (!dec_hit &&
          g_addr >= SLV_BASE[s*ADDR_W +: ADDR_W] &&
          g_addr <= SLV_LIMIT[s*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = SW'(s);
      end
    end
  end

  // Next-state, grant/pointer update, slave latch and DECERR beat counter
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (arb_found) begin
          gnt_nxt   = arb_idx;
          ptr_nxt   = (32'(arb_idx) == 32'(NUM_M - 1)) ? '0 : arb_idx + MW'(1);
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        // Both branches need ARVALID so that ADDR is never left without a handshake
        if (M_ARVALID[gnt]) begin
          if (dec_hit) begin
            if (S_ARREADY[dec_idx]) begin
              sel_nxt   = dec_idx;
              state_nxt = DATA;
            end
          end else begin
            cnt_nxt   = M_ARLEN[int'(gnt)*4 +: 4];
            state_nxt = ERR;
          end
        end
      end
      DATA: begin
        if (S_RVALID[sel] && M_RREADY[gnt] && S_RLAST[sel]) state_nxt = IDLE;
      end
      ERR: begin
        if (M_RREADY[gnt]) begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; the async reset returns to IDLE, which forces all outputs low
  always_ff @(posedge G_clk or negedge G_reset) begin
    if (!G_reset) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Combinational AR/R routing between the granted master and its slave
  always_comb begin
    M_ARREADY = '0;
    M_RVALID  = '0;
    M_RLAST   = '0;
    M_RRESP   = '0;
    M_RDATA   = '0;
    S_ARADDR  = '0;
    S_ARLEN   = '0;
    S_ARSIZE  = '0;
    S_ARBURST = '0;
    S_ARVALID = '0;
    S_RREADY  = '0;
    case (state)
      ADDR: begin
        if (dec_hit) begin
          S_ARADDR[int'(dec_idx)*ADDR_W +: ADDR_W] = g_addr;
          S_ARLEN[int'(dec_idx)*4 +: 4]            = M_ARLEN[int'(gnt)*4 +: 4];
          S_ARSIZE[int'(dec_idx)*3 +: 3]           = M_ARSIZE[int'(gnt)*3 +: 3];
          S_ARBURST[int'(dec_idx)*2 +: 2]          = M_ARBURST[int'(gnt)*2 +: 2];
          S_ARVALID[dec_idx]                       = M_ARVALID[gnt];
          M_ARREADY[gnt]                           = S_ARREADY[dec_idx];
        end else begin
          M_ARREADY[gnt] = 1'b1;
        end
      end
      DATA: begin
        M_RVALID[gnt]                          = S_RVALID[sel];
        M_RLAST[gnt]                           = S_RLAST[sel];
        M_RRESP[int'(gnt)*2 +: 2]              = S_RRESP[int'(sel)*2 +: 2];
        M_RDATA[int'(gnt)*DATA_W +: DATA_W]    = S_RDATA[int'(sel)*DATA_W +: DATA_W];
        S_RREADY[sel]                          = M_RREADY[gnt];
      end
      ERR: begin
        M_RVALID[gnt]             = 1'b1;
        M_RRESP[int'(gnt)*2 +: 2] = 2'b11;
        M_RLAST[gnt]              = (cnt == '0);
      end
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign grant_id = (state == IDLE) ? '0 : gnt;

endmodule

// File: tb/tb_axi_rd_interconnect_nxm.sv
// tb_axi_rd_interconnect_nxm: directed bench for the 2x2 configuration.
// A transaction-phase model predicts every DUT output on every cycle.
// Literal expectations per scenario pin down that model.
module tb_axi_rd_interconnect_nxm;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OUT_W = NM*(3 + 2 + DW) + NS*(AW + 4 + 3 + 2 + 2) + 2;

  logic clk = 1'b0;
  logic rst_n;

  logic [NM*AW-1:0] M_ARADDR;
  logic [NM*4-1:0]  M_ARLEN;
  logic [NM*3-1:0]  M_ARSIZE;
  logic [NM*2-1:0]  M_ARBURST;
  logic [NM-1:0]    M_ARVALID, M_RREADY, M_ARREADY, M_RVALID, M_RLAST;
  logic [NM*2-1:0]  M_RRESP;
  logic [NM*DW-1:0] M_RDATA;
  logic [NS*AW-1:0] S_ARADDR, SLV_BASE, SLV_LIMIT;
  logic [NS*4-1:0]  S_ARLEN;
  logic [NS*3-1:0]  S_ARSIZE;
  logic [NS*2-1:0]  S_ARBURST, S_RRESP;
  logic [NS-1:0]    S_ARVALID, S_RREADY, S_ARREADY, S_RVALID, S_RLAST;
  logic [NS*DW-1:0] S_RDATA;
  logic             busy;
  logic [0:0]       grant_id;
  logic [OUT_W-1:0] all_out;

  // Bench-side drive arrays
  logic [AW-1:0] m_araddr [NM];
  logic [3:0]    m_arlen  [NM];
  logic          m_arvalid[NM];
  logic          m_rready [NM];
  logic          s_arready[NS];
  logic          s_rvalid [NS];
  logic          s_rlast  [NS];
  logic [1:0]    s_rresp  [NS];
  logic [DW-1:0] s_rdata  [NS];
  logic [AW-1:0] base     [NS];
  logic [AW-1:0] limit    [NS];
  int            s_delay  [NS];
  logic [AW-1:0] s_cap_addr[NS];

  // Per-master results of the last read
  int          r_beats    [NM];
  logic [15:0] r_last_mask[NM];
  logic [1:0]  r_resp     [NM];
  logic [1:0]  r_resp_and [NM];
  logic [DW-1:0] r_data   [NM];
  logic [DW-1:0] r_data_or[NM];
  int          r_hs_cyc   [NM];
  int          r_end_cyc  [NM];
  int          order[$];

  int total = 0;
  int passed = 0;
  int cyc = 0;

  // Model state: phase 0 idle, 1 address, 2 slave data, 3 decode-error burst
  int ph = 0, own = 0, tgt = 0, rem = 0, mptr = 0;

  axi_rd_interconnect_nxm #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .G_clk(clk), .G_reset(rst_n),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARVALID(M_ARVALID), .M_RREADY(M_RREADY),
    .M_ARREADY(M_ARREADY), .M_RVALID(M_RVALID), .M_RLAST(M_RLAST),
    .M_RRESP(M_RRESP), .M_RDATA(M_RDATA),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_RREADY(S_RREADY),
    .S_ARREADY(S_ARREADY), .S_RVALID(S_RVALID), .S_RLAST(S_RLAST),
    .S_RRESP(S_RRESP), .S_RDATA(S_RDATA),
    .SLV_BASE(SLV_BASE), .SLV_LIMIT(SLV_LIMIT),
    .busy(busy), .grant_id(grant_id)
  );

  assign all_out = {M_ARREADY, M_RVALID, M_RLAST, M_RRESP, M_RDATA,
                    S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
                    busy, grant_id};

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Pack bench drive arrays onto the flattened buses
  always_comb begin
    M_ARADDR = '0; M_ARLEN = '0; M_ARSIZE = '0; M_ARBURST = '0; M_ARVALID = '0; M_RREADY = '0;
    S_ARREADY = '0; S_RVALID = '0; S_RLAST = '0; S_RRESP = '0; S_RDATA = '0;
    SLV_BASE = '0; SLV_LIMIT = '0;
    for (int i = 0; i < NM; i++) begin
      M_ARADDR[i*AW +: AW] = m_araddr[i];
      M_ARLEN[i*4 +: 4]    = m_arlen[i];
      M_ARSIZE[i*3 +: 3]   = 3'd2;
      M_ARBURST[i*2 +: 2]  = 2'b01;
      M_ARVALID[i]         = m_arvalid[i];
      M_RREADY[i]          = m_rready[i];
    end
    for (int i = 0; i < NS; i++) begin
      S_ARREADY[i]          = s_arready[i];
      S_RVALID[i]           = s_rvalid[i];
      S_RLAST[i]            = s_rlast[i];
      S_RRESP[i*2 +: 2]     = s_rresp[i];
      S_RDATA[i*DW +: DW]   = s_rdata[i];
      SLV_BASE[i*AW +: AW]  = base[i];
      SLV_LIMIT[i*AW +: AW] = limit[i];
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int s = 0; s < NS; s++)
      if (a >= base[s] && a <= limit[s]) return s;
    return -1;
  endfunction

  function automatic logic [DW-1:0] beat_data(input int s, input logic [AW-1:0] a, input int b);
    return {8'(s), a[15:0], 8'(b)};
  endfunction

  // Behavioural slave: ARREADY after s_delay cycles, then len+1 beats honouring RREADY
  task automatic slave_proc(input int s);
    logic [AW-1:0] a;
    logic [3:0]    len;
    logic          ok, hs;
    forever begin
      s_arready[s] = 1'b0; s_rvalid[s] = 1'b0; s_rlast[s] = 1'b0;
      s_rdata[s] = '0; s_rresp[s] = 2'b00;
      do @(negedge clk); while (!(S_ARVALID[s] && rst_n));
      @(posedge clk); #1;
      for (int d = 0; d < s_delay[s] && rst_n; d++) begin @(posedge clk); #1; end
      if (!rst_n) continue;
      s_arready[s] = 1'b1;
      @(negedge clk);
      a   = S_ARADDR[s*AW +: AW];
      len = S_ARLEN[s*4 +: 4];
      ok  = S_ARVALID[s];
      @(posedge clk); #1;
      s_arready[s] = 1'b0;
      if (!rst_n || !ok) continue;
      s_cap_addr[s] = a;
      for (int b = 0; b <= int'(len) && rst_n; b++) begin
        s_rvalid[s] = 1'b1;
        s_rlast[s]  = (b == int'(len));
        s_rdata[s]  = beat_data(s, a, b);
        s_rresp[s]  = (s == 1) ? 2'b01 : 2'b00;
        do begin
          @(negedge clk); hs = S_RREADY[s];
          @(posedge clk); #1;
        end while (!hs && rst_n);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      s_arready[i] = 1'b0; s_rvalid[i] = 1'b0; s_rlast[i] = 1'b0;
      s_rdata[i] = '0; s_rresp[i] = 2'b00; s_cap_addr[i] = '0;
    end
    fork
      slave_proc(0);
      slave_proc(1);
    join
  end

  // Master read; rready mode 0 = always, 1 = toggling, 2 = never
  task automatic do_read(input int m, input logic [AW-1:0] addr, input logic [3:0] len, input int mode);
    logic hs, done;
    r_beats[m] = 0; r_last_mask[m] = '0; r_resp_and[m] = 2'b11; r_data_or[m] = '0;
    r_resp[m] = 2'b00; r_data[m] = '0;
    m_araddr[m] = addr; m_arlen[m] = len; m_arvalid[m] = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = M_ARREADY[m] && rst_n;
      if (hs) order.push_back(m);
      @(posedge clk); #1;
      if (!rst_n) begin m_arvalid[m] = 1'b0; return; end
    end
    m_arvalid[m] = 1'b0;
    chk("ar_handshake", hs, 1'b1);
    if (!hs) return;
    r_hs_cyc[m] = cyc;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      m_rready[m] = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 1) : 1'b0;
      @(negedge clk);
      if (M_RVALID[m] && m_rready[m]) begin
        r_data[m]      = M_RDATA[m*DW +: DW];
        r_resp[m]      = M_RRESP[m*2 +: 2];
        r_resp_and[m]  = r_resp_and[m] & r_resp[m];
        r_data_or[m]   = r_data_or[m] | r_data[m];
        r_last_mask[m] = r_last_mask[m] | (16'(M_RLAST[m]) << r_beats[m]);
        r_beats[m]     = r_beats[m] + 1;
        done           = M_RLAST[m];
      end
      @(posedge clk); #1;
      if (!rst_n) begin m_rready[m] = 1'b0; return; end
    end
    m_rready[m] = 1'b0;
    r_end_cyc[m] = cyc;
    chk("r_complete", done, 1'b1);
  endtask

  // Per-cycle compare of all outputs against the transaction-phase model
  initial begin : cmp
    logic [NM-1:0]    e_arready, e_rvalid, e_rlast;
    logic [NM*2-1:0]  e_rresp;
    logic [NM*DW-1:0] e_rdata;
    logic [NS*AW-1:0] e_saddr;
    logic [NS*4-1:0]  e_slen;
    logic [NS*3-1:0]  e_ssize;
    logic [NS*2-1:0]  e_sburst;
    logic [NS-1:0]    e_sarvalid, e_srready;
    int t, idx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin ph = 0; mptr = 0; end
      e_arready = '0; e_rvalid = '0; e_rlast = '0; e_rresp = '0; e_rdata = '0;
      e_saddr = '0; e_slen = '0; e_ssize = '0; e_sburst = '0; e_sarvalid = '0; e_srready = '0;
      t = (ph == 1) ? decode(m_araddr[own]) : -1;
      if (ph == 1) begin
        if (t >= 0) begin
          e_saddr[t*AW +: AW] = m_araddr[own];
          e_slen[t*4 +: 4]    = m_arlen[own];
          e_ssize[t*3 +: 3]   = 3'd2;
          e_sburst[t*2 +: 2]  = 2'b01;
          e_sarvalid[t]       = m_arvalid[own];
          e_arready[own]      = s_arready[t];
        end else begin
          e_arready[own] = 1'b1;
        end
      end else if (ph == 2) begin
        e_rvalid[own]           = s_rvalid[tgt];
        e_rlast[own]            = s_rlast[tgt];
        e_rresp[own*2 +: 2]     = s_rresp[tgt];
        e_rdata[own*DW +: DW]   = s_rdata[tgt];
        e_srready[tgt]          = m_rready[own];
      end else if (ph == 3) begin
        e_rvalid[own]       = 1'b1;
        e_rresp[own*2 +: 2] = 2'b11;
        e_rlast[own]        = (rem == 0);
      end
      chk("master_side", {M_ARREADY, M_RVALID, M_RLAST, M_RRESP, M_RDATA},
          {e_arready, e_rvalid, e_rlast, e_rresp, e_rdata});
      chk("slave_side", {S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY},
          {e_saddr, e_slen, e_ssize, e_sburst, e_sarvalid, e_srready});
      chk("busy_grant", {busy, grant_id}, {ph != 0, (ph != 0) ? own[0] : 1'b0});
      if (rst_n) begin
        case (ph)
          0: begin
            for (int k = NM - 1; k >= 0; k--) begin
              idx = (mptr + k) % NM;
              if (m_arvalid[idx]) begin own = idx; ph = 1; end
            end
            if (ph == 1) mptr = (own + 1) % NM;
          end
          1: begin
            if (t >= 0) begin
              if (m_arvalid[own] && s_arready[t]) begin tgt = t; ph = 2; end
            end else if (m_arvalid[own]) begin
              rem = int'(m_arlen[own]); ph = 3;
            end
          end
          2: if (s_rvalid[tgt] && m_rready[own] && s_rlast[tgt]) ph = 0;
          3: if (m_rready[own]) begin
               if (rem == 0) ph = 0;
               else rem = rem - 1;
             end
          default: ph = 0;
        endcase
      end
    end
  end

  int rr_exp[4] = '{1, 0, 1, 0};

  initial begin : main
    for (int i = 0; i < NM; i++) begin
      m_araddr[i] = '0; m_arlen[i] = '0; m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
    end
    base[0] = 32'd1;  limit[0] = 32'd5;
    base[1] = 32'd10; limit[1] = 32'd15;
    s_delay[0] = 0; s_delay[1] = 2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_out, '0);
    rst_n = 1'b1;

    // Single-beat read routed to S1
    do_read(0, 32'd12, 4'd0, 0);
    chk("basic_beats", r_beats[0], 1);
    chk("basic_data", r_data[0], 32'h0100_0C00);
    chk("basic_resp", r_resp[0], 2'b01);
    chk("basic_slave_addr", s_cap_addr[1], 32'd12);
    chk("basic_idle_after", busy, 1'b0);

    // Both masters request continuously; ptr is 1 after the M0 grant above
    order.delete();
    fork
      begin do_read(0, 32'd3, 4'd0, 0); do_read(0, 32'd3, 4'd0, 0); end
      begin do_read(1, 32'd3, 4'd0, 0); do_read(1, 32'd3, 4'd0, 0); end
    join
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_grant", (i < order.size()) ? order[i] : -1, rr_exp[i]);

    // Unmapped address: three DECERR beats on consecutive cycles
    do_read(1, 32'd7, 4'd2, 0);
    chk("decerr_beats", r_beats[1], 3);
    chk("decerr_last", r_last_mask[1], 16'b100);
    chk("decerr_resp", r_resp_and[1], 2'b11);
    chk("decerr_data", r_data_or[1], '0);
    chk("decerr_cycles", r_end_cyc[1] - r_hs_cyc[1], 3);

    // Two-beat read with toggling RREADY
    do_read(0, 32'd14, 4'd1, 1);
    chk("bp_beats", r_beats[0], 2);
    chk("bp_last", r_last_mask[0], 16'b10);
    chk("bp_data", r_data[0], 32'h0100_0E01);

    // Overlapping windows: lowest slave index wins
    base[0] = 32'd1; limit[0] = 32'd12;
    do_read(1, 32'd11, 4'd0, 0);
    chk("overlap_data", r_data[1], 32'h0000_0B00);
    chk("overlap_resp", r_resp[1], 2'b00);
    chk("overlap_slave_addr", s_cap_addr[0], 32'd11);

    // Reset in the middle of a data burst
    fork
      do_read(0, 32'd14, 4'd3, 2);
      begin
        int w;
        w = 0;
        do begin @(negedge clk); w++; end while (!M_RVALID[0] && w < 50);
        chk("rst_reach_data", M_RVALID[0], 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", all_out, '0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    order.delete();
    fork
      do_read(0, 32'd3, 4'd0, 0);
      do_read(1, 32'd3, 4'd0, 0);
    join
    chk("rst_first_grant", (order.size() > 0) ? order[0] : -1, 0);
    chk("rst_second_grant", (order.size() > 1) ? order[1] : -1, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
